// File: rtl/cuboid_frame_tx.sv
// Serial frame transmitter: buffers {length, width, height} triples in a FIFO
// and emits each triple as a contiguous 3-beat frame for the cuboid processor.
module cuboid_frame_tx #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned GAP_CYCLES = 0
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          s_valid,
    output logic                          s_ready,
    input  logic [DATA_W-1:0]             s_length,
    input  logic [DATA_W-1:0]             s_width,
    input  logic [DATA_W-1:0]             s_height,
    output logic [DATA_W-1:0]             out_data,
    output logic                          out_valid,
    output logic                          out_start,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [15:0]                   frames_sent
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned LW      = AW + 1;
    localparam int unsigned ENTRY_W = 3 * DATA_W;
    localparam int unsigned GAP_W   = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BEAT_W = 2'd1,
        BEAT_H = 2'd2,
        GAP    = 2'd3
    } state_t;

    state_t state, state_d;

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]      wr_ptr;
    logic [AW-1:0]      rd_ptr;
    logic [LW-1:0]      level;
    logic               push;
    logic               pop;
    logic               fifo_empty;
    logic [ENTRY_W-1:0] head;
    logic [DATA_W-1:0]  head_l;
    logic [DATA_W-1:0]  head_w;
    logic [DATA_W-1:0]  head_h;

    // Holding registers keep the in-flight frame stable against later pushes
    logic [DATA_W-1:0]  hold_w, hold_w_d;
    logic [DATA_W-1:0]  hold_h, hold_h_d;
    logic [GAP_W-1:0]   gap_cnt, gap_cnt_d;
    logic [DATA_W-1:0]  out_data_d;
    logic               out_valid_d;
    logic               out_start_d;
    logic [15:0]        frames_sent_d;

    assign s_ready    = (level != LW'(FIFO_DEPTH));
    assign fifo_empty = (level == '0);
    assign push       = s_valid && s_ready;
    assign fifo_level = level;
    assign busy       = (state != IDLE) || !fifo_empty;

    assign head   = mem[rd_ptr];
    assign head_l = head[ENTRY_W-1 -: DATA_W];
    assign head_w = head[2*DATA_W-1 -: DATA_W];
    assign head_h = head[DATA_W-1:0];

    // FIFO storage; contents need no reset since level gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {s_length, s_width, s_height};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            out_data    <= '0;
            out_valid   <= 1'b0;
            out_start   <= 1'b0;
            hold_w      <= '0;
            hold_h      <= '0;
            gap_cnt     <= '0;
            frames_sent <= '0;
        end else begin
            state       <= state_d;
            out_data    <= out_data_d;
            out_valid   <= out_valid_d;
            out_start   <= out_start_d;
            hold_w      <= hold_w_d;
            hold_h      <= hold_h_d;
            gap_cnt     <= gap_cnt_d;
            frames_sent <= frames_sent_d;
        end
    end

    // Next-state and next-output logic; outputs default to an idle bus
    always_comb begin
        state_d       = state;
        pop           = 1'b0;
        out_data_d    = '0;
        out_valid_d   = 1'b0;
        out_start_d   = 1'b0;
        hold_w_d      = hold_w;
        hold_h_d      = hold_h;
        gap_cnt_d     = gap_cnt;
        frames_sent_d = frames_sent;

        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    pop         = 1'b1;
                    out_data_d  = head_l;
                    out_valid_d = 1'b1;
                    out_start_d = 1'b1;
                    hold_w_d    = head_w;
                    hold_h_d    = head_h;
                    state_d     = BEAT_W;
                end
            end
            BEAT_W: begin
                out_data_d  = hold_w;
                out_valid_d = 1'b1;
                state_d     = BEAT_H;
            end
            BEAT_H: begin
                out_data_d    = hold_h;
                out_valid_d   = 1'b1;
                frames_sent_d = frames_sent + 16'd1;
                if (GAP_CYCLES != 0) begin
                    gap_cnt_d = GAP_W'(GAP_CYCLES);
                    state_d   = GAP;
                end else begin
                    state_d   = IDLE;
                end
            end
            GAP: begin
                gap_cnt_d = gap_cnt - GAP_W'(1);
                if (gap_cnt <= GAP_W'(1)) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cuboid_frame_tx.sv
// Self-checking bench for cuboid_frame_tx: scoreboard of expected beats plus
// per-scenario timing checks on a GAP=0 instance and a GAP=2 instance.
module tb_cuboid_frame_tx;

    logic        clk;
    logic        rst;
    logic        s_valid;
    logic        s_valid2;
    logic [15:0] s_length;
    logic [15:0] s_width;
    logic [15:0] s_height;

    logic        a_s_ready, a_out_valid, a_out_start, a_busy;
    logic [15:0] a_out_data, a_frames;
    logic [2:0]  a_level;

    logic        b_s_ready, b_out_valid, b_out_start, b_busy;
    logic [15:0] b_out_data, b_frames;
    logic [2:0]  b_level;

    typedef struct {
        logic [15:0] d;
        logic        s;
    } beat_t;

    beat_t sb[$];
    beat_t exp_b;
    int    checks = 0;
    int    errors = 0;
    bit    mon_en = 0;

    cuboid_frame_tx #(.DATA_W(16), .FIFO_DEPTH(4), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(a_s_ready),
        .s_length(s_length), .s_width(s_width), .s_height(s_height),
        .out_data(a_out_data), .out_valid(a_out_valid), .out_start(a_out_start),
        .busy(a_busy), .fifo_level(a_level), .frames_sent(a_frames)
    );

    cuboid_frame_tx #(.DATA_W(16), .FIFO_DEPTH(4), .GAP_CYCLES(2)) dut2 (
        .clk(clk), .rst(rst), .s_valid(s_valid2), .s_ready(b_s_ready),
        .s_length(s_length), .s_width(s_width), .s_height(s_height),
        .out_data(b_out_data), .out_valid(b_out_valid), .out_start(b_out_start),
        .busy(b_busy), .fifo_level(b_level), .frames_sent(b_frames)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard monitor for the GAP=0 instance
    always @(negedge clk) begin
        if (mon_en) begin
            checks++;
            if (a_out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: data=%0d start=%0b with empty scoreboard",
                             a_out_data, a_out_start);
                end else begin
                    exp_b = sb.pop_front();
                    if (a_out_data !== exp_b.d || a_out_start !== exp_b.s) begin
                        errors++;
                        $display("FAIL beat_data: got data=%0d start=%0b, expected data=%0d start=%0b",
                                 a_out_data, a_out_start, exp_b.d, exp_b.s);
                    end
                end
            end else if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_out_start !== 1'b0) begin
                errors++;
                $display("FAIL idle_bus: got valid=%0b data=%0d start=%0b, expected 0/0/0",
                         a_out_valid, a_out_data, a_out_start);
            end
        end
    end

    // Offer one triple to dut0 at a negedge, wait for acceptance, record beats
    task automatic push(input logic [15:0] l, input logic [15:0] w, input logic [15:0] h,
                        output bit stalled);
        int t;
        stalled  = 0;
        t        = 0;
        s_valid  = 1'b1;
        s_length = l;
        s_width  = w;
        s_height = h;
        while (a_s_ready !== 1'b1 && t < 40) begin
            stalled = 1;
            checks++;
            if (a_level !== 3'd4) begin
                errors++;
                $display("FAIL stall_level: s_ready=0 with level=%0d, expected 4", a_level);
            end
            @(negedge clk);
            t++;
        end
        if (t >= 40) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: s_ready stayed %0b, expected 1", a_s_ready);
            s_valid = 1'b0;
        end else begin
            @(posedge clk);
            sb.push_back('{d: l, s: 1'b1});
            sb.push_back('{d: w, s: 1'b0});
            sb.push_back('{d: h, s: 1'b0});
            @(negedge clk);
            s_valid = 1'b0;
        end
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((a_busy !== 1'b0 || sb.size() != 0) && t < 200) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 200) begin
            errors++;
            $display("FAIL idle_timeout: busy=%0b pending=%0d, expected 0/0", a_busy, sb.size());
        end
    endtask

    task automatic test_reset();
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_out_start !== 1'b0 ||
            a_level !== 3'd0 || a_s_ready !== 1'b1 || a_frames !== 16'd0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: valid=%0b data=%0d start=%0b level=%0d ready=%0b frames=%0d busy=%0b, expected 0/0/0/0/1/0/0",
                     a_out_valid, a_out_data, a_out_start, a_level, a_s_ready, a_frames, a_busy);
        end
        checks++;
        if (b_out_valid !== 1'b0 || b_level !== 3'd0 || b_frames !== 16'd0) begin
            errors++;
            $display("FAIL reset_state_gap: valid=%0b level=%0d frames=%0d, expected 0/0/0",
                     b_out_valid, b_level, b_frames);
        end
        rst    = 1'b0;
        mon_en = 1;
    endtask

    task automatic test_single();
        bit st;
        push(16'd3, 16'd4, 16'd5, st);
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_latency: valid=%0b one cycle after accept, expected 0", a_out_valid);
        end
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_start !== 1'b1 || a_out_data !== 16'd3 || a_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_beat_l: valid=%0b start=%0b data=%0d busy=%0b, expected 1/1/3/1",
                     a_out_valid, a_out_start, a_out_data, a_busy);
        end
        @(negedge clk);
        checks++;
        if (a_out_start !== 1'b0 || a_out_data !== 16'd4) begin
            errors++;
            $display("FAIL single_beat_w: start=%0b data=%0d, expected 0/4", a_out_start, a_out_data);
        end
        @(negedge clk);
        checks++;
        if (a_out_data !== 16'd5 || a_frames !== 16'd1) begin
            errors++;
            $display("FAIL single_beat_h: data=%0d frames=%0d, expected 5/1", a_out_data, a_frames);
        end
        wait_idle();
    endtask

    task automatic test_back_to_back();
        logic [15:0] f0;
        f0 = a_frames;
        fork
            begin
                bit st;
                for (int i = 0; i < 4; i++) begin
                    push(16'(100 + i * 3), 16'(101 + i * 3), 16'(102 + i * 3), st);
                    checks++;
                    if (st) begin
                        errors++;
                        $display("FAIL b2b_ready: push %0d saw s_ready=0, expected 1", i);
                    end
                end
            end
            begin
                int t;
                t = 0;
                while (a_out_start !== 1'b1 && t < 20) begin
                    @(negedge clk);
                    t++;
                end
                for (int k = 0; k < 12; k++) begin
                    checks++;
                    if (a_out_valid !== 1'b1 || a_out_start !== ((k % 3) == 0)) begin
                        errors++;
                        $display("FAIL b2b_contig: beat %0d valid=%0b start=%0b, expected 1/%0b",
                                 k, a_out_valid, a_out_start, ((k % 3) == 0));
                    end
                    @(negedge clk);
                end
                checks++;
                if (a_out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_end: valid=%0b after 12 beats, expected 0", a_out_valid);
                end
            end
        join
        wait_idle();
        checks++;
        if (a_frames !== f0 + 16'd4) begin
            errors++;
            $display("FAIL b2b_frames: frames=%0d, expected %0d", a_frames, f0 + 16'd4);
        end
    endtask

    task automatic test_full();
        bit st;
        bit any_stall;
        any_stall = 0;
        for (int i = 0; i < 7; i++) begin
            push(16'(200 + i), 16'(300 + i), 16'(400 + i), st);
            any_stall = any_stall | st;
        end
        checks++;
        if (!any_stall) begin
            errors++;
            $display("FAIL full_stall: s_ready never dropped over 7 pushes, expected a stall at level 4");
        end
        wait_idle();
    endtask

    task automatic test_gap();
        int t;
        @(negedge clk);
        s_valid2 = 1'b1;
        s_length = 16'd10; s_width = 16'd11; s_height = 16'd12;
        @(posedge clk);
        @(negedge clk);
        s_length = 16'd20; s_width = 16'd21; s_height = 16'd22;
        checks++;
        if (b_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL gap_ready: s_ready=%0b, expected 1", b_s_ready);
        end
        @(posedge clk);
        @(negedge clk);
        s_valid2 = 1'b0;
        t = 0;
        while (b_out_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (b_out_data !== 16'd10 || b_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL gap_l1: data=%0d valid=%0b, expected 10/1", b_out_data, b_out_valid);
        end
        repeat (2) @(negedge clk);
        checks++;
        if (b_out_data !== 16'd12 || b_frames !== 16'd1) begin
            errors++;
            $display("FAIL gap_h1: data=%0d frames=%0d, expected 12/1", b_out_data, b_frames);
        end
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            checks++;
            if (b_out_valid !== 1'b0 || b_out_data !== 16'd0) begin
                errors++;
                $display("FAIL gap_idle: gap cycle %0d valid=%0b data=%0d, expected 0/0",
                         k, b_out_valid, b_out_data);
            end
        end
        @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b1 || b_out_start !== 1'b1 || b_out_data !== 16'd20) begin
            errors++;
            $display("FAIL gap_l2: valid=%0b start=%0b data=%0d, expected 1/1/20",
                     b_out_valid, b_out_start, b_out_data);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (b_out_valid !== 1'b0 || b_frames !== 16'd2) begin
            errors++;
            $display("FAIL gap_end: valid=%0b frames=%0d, expected 0/2", b_out_valid, b_frames);
        end
    endtask

    task automatic test_reset_mid();
        bit st;
        push(16'd7, 16'd8, 16'd9, st);
        push(16'd1, 16'd1, 16'd1, st);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || a_out_start !== 1'b0 || a_out_data !== 16'd8 || a_level !== 3'd1) begin
            errors++;
            $display("FAIL rstmid_beat_w: valid=%0b start=%0b data=%0d level=%0d, expected 1/0/8/1",
                     a_out_valid, a_out_start, a_out_data, a_level);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (a_out_valid !== 1'b0 || a_out_data !== 16'd0 || a_level !== 3'd0 ||
            a_frames !== 16'd0 || a_s_ready !== 1'b1) begin
            errors++;
            $display("FAIL rstmid_state: valid=%0b data=%0d level=%0d frames=%0d ready=%0b, expected 0/0/0/0/1",
                     a_out_valid, a_out_data, a_level, a_frames, a_s_ready);
        end
        sb.delete();
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if (a_out_valid !== 1'b0) begin
                errors++;
                $display("FAIL rstmid_no_beat: cycle %0d valid=%0b data=%0d, expected 0",
                         k, a_out_valid, a_out_data);
            end
        end
    endtask

    task automatic test_cuboid_chain();
        bit st;
        int t;
        int l, w, h;
        push(16'd2, 16'd3, 16'd4, st);
        t = 0;
        while (a_out_start !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        l = int'(a_out_data);
        @(negedge clk);
        w = int'(a_out_data);
        @(negedge clk);
        h = int'(a_out_data);
        checks++;
        if (2 * (l * w + w * h + l * h) != 52 || l * w * h != 24 || 4 * (l + w + h) != 36) begin
            errors++;
            $display("FAIL chain_cuboid: A=%0d V=%0d P=%0d, expected 52/24/36",
                     2 * (l * w + w * h + l * h), l * w * h, 4 * (l + w + h));
        end
        wait_idle();
    endtask

    initial begin
        rst      = 1'b1;
        s_valid  = 1'b0;
        s_valid2 = 1'b0;
        s_length = '0;
        s_width  = '0;
        s_height = '0;
        repeat (3) @(posedge clk);
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_gap();
        test_reset_mid();
        test_cuboid_chain();
        checks++;
        if (sb.size() != 0 || a_busy !== 1'b0) begin
            errors++;
            $display("FAIL final_drain: pending=%0d busy=%0b, expected 0/0", sb.size(), a_busy);
        end
        mon_en = 0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
